// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        VEC_LO,
        VEC_HI,
        FETCH_OP,
        FETCH_LO,
        FETCH_HI,
        HOLD
    } fetch_state_t;

    typedef logic [1:0] instr_len_t;

    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;

    // Redirects are not honoured until the reset vector has been loaded.
    function automatic logic is_vec_state(input fetch_state_t st);
        return (st == VEC_LO) || (st == VEC_HI);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-read, redirect and decoder-bundle signals of the fetch unit.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  opcode_o;
    logic [15:0] data_o;
    logic [15:0] pc_o;
    instr_len_t  len_o;

    modport master (
        output mem_req_o, mem_addr_o, valid_o, opcode_o, data_o, pc_o, len_o,
        input  mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, valid_o, opcode_o, data_o, pc_o, len_o,
        output mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

endinterface

// File: rtl/fetch_unit_instr_len.sv
// Combinational instruction-length decode from the opcode byte (1..3 bytes).
module instr_len
    import fetch_unit_pkg::*;
(
    input  logic [7:0] opcode,
    output instr_len_t len
);

    logic [1:0] c;
    logic [2:0] b;

    assign c = opcode[1:0];
    assign b = opcode[4:2];

    always_comb begin
        len = 2'd1;
        if (c != 2'b11) begin
            case (b)
                3'b011, 3'b111: len = 2'd3;
                3'b110:         len = (c == 2'b01) ? 2'd3 : 2'd1;
                3'b001, 3'b101: len = 2'd2;
                3'b010:         len = (c == 2'b01) ? 2'd2 : 2'd1;
                3'b100:         len = (c == 2'b10) ? 2'd1 : 2'd2;
                default: begin
                    // b == 000: c=00 is a mix of implied, immediate and absolute forms
                    if (c != 2'b00)
                        len = 2'd2;
                    else if (opcode == 8'h20)
                        len = 2'd3;
                    else if (opcode == 8'hA0 || opcode == 8'hC0 || opcode == 8'hE0)
                        len = 2'd2;
                    else
                        len = 2'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial fetch: loads PC from the reset vector, then reads opcode and
// operand bytes one outstanding read at a time and presents a decoded bundle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);

    fetch_state_t state_reg;
    logic [15:0]  pc_reg;
    logic [15:0]  mem_addr_reg;
    logic [15:0]  data_reg;
    logic [7:0]   opcode_reg;
    instr_len_t   len_reg;
    instr_len_t   op_len;
    logic         mem_req_reg;
    logic         valid_reg;
    logic         pending_reg;
    logic         drop_reg;
    logic         need_req_reg;

    logic         rsp_take;
    logic         handshake;
    logic         redirect_take;
    logic [15:0]  pc_plus1;
    logic [15:0]  pc_plus2;
    logic [15:0]  pc_next_seq;
    logic [15:0]  resume_addr;

    instr_len u_instr_len (
        .opcode (bus.mem_rdata_i),
        .len    (op_len)
    );

    assign rsp_take      = bus.mem_rvalid_i && pending_reg;
    assign handshake     = valid_reg && bus.ready_i;
    assign redirect_take = bus.redirect_i && !is_vec_state(state_reg);
    assign pc_plus1      = pc_reg + 16'd1;
    assign pc_plus2      = pc_reg + 16'd2;
    assign pc_next_seq   = pc_reg + {14'd0, len_reg};
    // A deferred request is either the very first vector read or a post-redirect opcode read.
    assign resume_addr   = (state_reg == VEC_LO) ? RESET_VECTOR : pc_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= VEC_LO;
            pc_reg       <= 16'h0000;
            mem_addr_reg <= 16'h0000;
            data_reg     <= 16'h0000;
            opcode_reg   <= 8'h00;
            len_reg      <= 2'd0;
            mem_req_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            drop_reg     <= 1'b0;
            need_req_reg <= 1'b1;
        end else begin
            mem_req_reg <= 1'b0;
            if (rsp_take)
                pending_reg <= 1'b0;

            if (redirect_take) begin
                pc_reg    <= bus.redirect_pc_i;
                valid_reg <= 1'b0;
                state_reg <= FETCH_OP;
                // A read still in flight must drain before the new opcode read may issue.
                if (pending_reg && !bus.mem_rvalid_i) begin
                    drop_reg     <= 1'b1;
                    need_req_reg <= 1'b1;
                end else begin
                    drop_reg     <= 1'b0;
                    need_req_reg <= 1'b0;
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= bus.redirect_pc_i;
                    pending_reg  <= 1'b1;
                end
            end else if (need_req_reg) begin
                if (!pending_reg || bus.mem_rvalid_i) begin
                    drop_reg     <= 1'b0;
                    need_req_reg <= 1'b0;
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= resume_addr;
                    pending_reg  <= 1'b1;
                end
            end else if (rsp_take) begin
                case (state_reg)
                    VEC_LO: begin
                        pc_reg[7:0]  <= bus.mem_rdata_i;
                        state_reg    <= VEC_HI;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= RESET_VECTOR + 16'd1;
                        pending_reg  <= 1'b1;
                    end
                    VEC_HI: begin
                        pc_reg[15:8] <= bus.mem_rdata_i;
                        state_reg    <= FETCH_OP;
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= {bus.mem_rdata_i, pc_reg[7:0]};
                        pending_reg  <= 1'b1;
                    end
                    FETCH_OP: begin
                        opcode_reg <= bus.mem_rdata_i;
                        len_reg    <= op_len;
                        data_reg   <= 16'h0000;
                        if (op_len != 2'd1) begin
                            state_reg    <= FETCH_LO;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pc_plus1;
                            pending_reg  <= 1'b1;
                        end else begin
                            state_reg <= HOLD;
                            valid_reg <= 1'b1;
                        end
                    end
                    FETCH_LO: begin
                        data_reg[7:0] <= bus.mem_rdata_i;
                        if (len_reg == 2'd3) begin
                            state_reg    <= FETCH_HI;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= pc_plus2;
                            pending_reg  <= 1'b1;
                        end else begin
                            state_reg <= HOLD;
                            valid_reg <= 1'b1;
                        end
                    end
                    FETCH_HI: begin
                        data_reg[15:8] <= bus.mem_rdata_i;
                        state_reg      <= HOLD;
                        valid_reg      <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (handshake) begin
                valid_reg    <= 1'b0;
                pc_reg       <= pc_next_seq;
                state_reg    <= FETCH_OP;
                mem_req_reg  <= 1'b1;
                mem_addr_reg <= pc_next_seq;
                pending_reg  <= 1'b1;
            end
        end
    end

    assign bus.mem_req_o  = mem_req_reg;
    assign bus.mem_addr_o = mem_addr_reg;
    assign bus.valid_o    = valid_reg;
    assign bus.opcode_o   = opcode_reg;
    assign bus.data_o     = data_reg;
    assign bus.pc_o       = pc_reg;
    assign bus.len_o      = len_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory with programmable latency,
// program-level model of expected bundles and request addresses.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [15:0] RV = 16'hFFFC;

    logic clk_i = 1'b0;
    logic rst_i;
    fetch_unit_if bus();

    fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Byte memory; a response arrives lat cycles after the request cycle.
    logic [7:0]  mem [0:65535];
    int          lat = 1;
    logic        mem_busy;
    int          mem_cnt;
    logic [15:0] mem_addr_q;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.mem_rvalid_i <= 1'b0;
            bus.mem_rdata_i  <= 8'h00;
            mem_busy         <= 1'b0;
            mem_cnt          <= 0;
            mem_addr_q       <= 16'h0000;
        end else begin
            bus.mem_rvalid_i <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    bus.mem_rvalid_i <= 1'b1;
                    bus.mem_rdata_i  <= mem[mem_addr_q];
                    mem_busy         <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (bus.mem_req_o) begin
                if (lat <= 1) begin
                    bus.mem_rvalid_i <= 1'b1;
                    bus.mem_rdata_i  <= mem[bus.mem_addr_o];
                end else begin
                    mem_busy   <= 1'b1;
                    mem_cnt    <= lat - 1;
                    mem_addr_q <= bus.mem_addr_o;
                end
            end
        end
    end

    // Instruction length straight from the opcode table.
    function automatic int model_len(input logic [7:0] op);
        logic [2:0] grp;
        logic [1:0] cc;
        grp = op[4:2];
        cc  = op[1:0];
        if (cc == 2'b11) return 1;
        if (op == 8'h20) return 3;
        if (grp == 3'b011 || grp == 3'b111) return 3;
        if (grp == 3'b001 || grp == 3'b101) return 2;
        if (grp == 3'b110) return (cc == 2'b01) ? 3 : 1;
        if (grp == 3'b010) return (cc == 2'b01) ? 2 : 1;
        if (grp == 3'b100) return (cc == 2'b10) ? 1 : 2;
        if (cc != 2'b00) return 2;
        if (op == 8'hA0 || op == 8'hC0 || op == 8'hE0) return 2;
        return 1;
    endfunction

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] data;
        logic [15:0] pc;
        logic [1:0]  len;
    } bundle_t;

    bundle_t     hs_q[$];
    logic [15:0] req_q[$];
    int          req_cyc[$];

    logic [15:0] model_pc;
    int          vec_k, req_k, outstanding, cyc, exp_len;
    logic [15:0] exp_addr, exp_data;
    logic        prev_hold;
    bundle_t     prev_b;

    // Per-cycle comparison against the program-level model.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            chk("reset_ctl", {bus.mem_req_o, bus.valid_o, bus.len_o, bus.opcode_o}, 32'h0);
            chk("reset_pc_data", {bus.pc_o, bus.data_o}, 32'h0);
            chk("reset_addr", bus.mem_addr_o, 32'h0);
            vec_k       = 0;
            req_k       = 0;
            outstanding = 0;
            prev_hold   = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("stall_valid", bus.valid_o, 1);
                chk("stall_op_len", {bus.opcode_o, bus.len_o}, {prev_b.op, prev_b.len});
                chk("stall_pc_data", {bus.pc_o, bus.data_o}, {prev_b.pc, prev_b.data});
            end
            if (bus.mem_req_o) begin
                chk("one_outstanding", outstanding, 0);
                chk("req_while_valid", bus.valid_o, 0);
                if (vec_k < 2) begin
                    exp_addr = RV + 16'(vec_k);
                    vec_k++;
                    if (vec_k == 2) model_pc = {mem[RV + 16'd1], mem[RV]};
                end else begin
                    exp_addr = model_pc + 16'(req_k);
                    chk("req_within_len", (req_k < model_len(mem[model_pc])), 1);
                    req_k++;
                end
                chk("req_addr", bus.mem_addr_o, exp_addr);
                req_q.push_back(bus.mem_addr_o);
                req_cyc.push_back(cyc);
                outstanding++;
            end
            if (bus.mem_rvalid_i) outstanding--;
            if (bus.valid_o && bus.ready_i) begin
                exp_len = model_len(mem[model_pc]);
                if (exp_len == 3)
                    exp_data = {mem[model_pc + 16'd2], mem[model_pc + 16'd1]};
                else if (exp_len == 2)
                    exp_data = {8'h00, mem[model_pc + 16'd1]};
                else
                    exp_data = 16'h0000;
                chk("hs_pc", bus.pc_o, model_pc);
                chk("hs_opcode", bus.opcode_o, mem[model_pc]);
                chk("hs_len", bus.len_o, exp_len);
                chk("hs_data", bus.data_o, exp_data);
                chk("hs_reads", req_k, exp_len);
                hs_q.push_back({bus.opcode_o, bus.data_o, bus.pc_o, bus.len_o});
                model_pc = model_pc + 16'(exp_len);
                req_k    = 0;
            end
            if (bus.redirect_i && vec_k >= 2) begin
                model_pc = bus.redirect_pc_i;
                req_k    = 0;
            end
            prev_hold = bus.valid_o && !bus.ready_i && !bus.redirect_i;
            prev_b    = {bus.opcode_o, bus.data_o, bus.pc_o, bus.len_o};
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.valid_o && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_valid_seen"}, bus.valid_o, 1);
    endtask

    task automatic take(input string name);
        wait_valid(name);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    task automatic wait_reqs(input int count, input string name);
        int n;
        n = 0;
        while (req_q.size() < count && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_req_seen"}, (req_q.size() >= count), 1);
    endtask

    task automatic chk_bundle(input string name, input int idx, input logic [7:0] op,
                              input logic [15:0] data, input logic [15:0] pc, input logic [1:0] len);
        bundle_t b;
        chk({name, "_present"}, (hs_q.size() > idx), 1);
        if (hs_q.size() > idx) begin
            b = hs_q[idx];
            chk({name, "_op"}, b.op, op);
            chk({name, "_data"}, b.data, data);
            chk({name, "_pc"}, b.pc, pc);
            chk({name, "_len"}, b.len, len);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int n0, h0, w, n;
        rst_i             = 1'b1;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hEA;
        mem[16'h8001] = 8'hA9; mem[16'h8002] = 8'h42;
        mem[16'h8003] = 8'h8D; mem[16'h8004] = 8'h00; mem[16'h8005] = 8'h02;
        mem[16'h8006] = 8'h4C; mem[16'h8007] = 8'h00; mem[16'h8008] = 8'h90;
        mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h05;
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'h8D; mem[16'h0002] = 8'h00; mem[16'h0003] = 8'h03;

        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        tick();
        chk("first_req", bus.mem_req_o, 1);
        chk("first_addr", bus.mem_addr_o, 16'hFFFC);

        // Reset vector then three instruction lengths, stalling on the 2-byte one.
        take("b0");
        wait_valid("b1");
        n0 = req_q.size();
        h0 = hs_q.size();
        repeat (5) tick();
        chk("stall_no_req", req_q.size(), n0);
        chk("stall_no_hs", hs_q.size(), h0);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        chk("stall_one_hs", hs_q.size(), h0 + 1);
        chk("valid_falls", bus.valid_o, 0);
        lat = 3;
        take("b2");
        chk("vec_req0", req_q[0], 16'hFFFC);
        chk("vec_req1", req_q[1], 16'hFFFD);
        chk("first_opcode_req", req_q[2], 16'h8000);
        chk_bundle("lda", 1, 8'hA9, 16'h0042, 16'h8001, 2'd2);
        chk_bundle("nop", 0, 8'hEA, 16'h0000, 16'h8000, 2'd1);
        chk_bundle("sta", 2, 8'h8D, 16'h0200, 16'h8003, 2'd3);

        // Redirect while the 8006 opcode read is in flight.
        n0 = req_q.size();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 16'hC000;
        tick();
        bus.redirect_i = 1'b0;
        wait_reqs(n0 + 2, "redirect");
        lat = 1;
        chk("stale_req_addr", req_q[n0], 16'h8006);
        chk("redirect_req_addr", req_q[n0 + 1], 16'hC000);
        chk("drop_gap", req_cyc[n0 + 1] - req_cyc[n0], 4);

        // Handshake and redirect together, then the wrapping 3-byte instruction.
        wait_valid("ldx");
        w = req_q.size();
        h0 = hs_q.size();
        bus.ready_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 16'hFFFE;
        tick();
        bus.ready_i    = 1'b0;
        bus.redirect_i = 1'b0;
        chk_bundle("ldx", h0, 8'hA2, 16'h0005, 16'hC000, 2'd2);
        wait_valid("wrap");
        lat = 3;
        take("wrap");
        wait_reqs(w + 4, "wrap");
        chk_bundle("jmp_wrap", h0 + 1, 8'h4C, 16'h1234, 16'hFFFE, 2'd3);
        chk("wrap_req_op", req_q[w], 16'hFFFE);
        chk("wrap_req_lo", req_q[w + 1], 16'hFFFF);
        chk("wrap_req_hi", req_q[w + 2], 16'h0000);
        chk("wrap_next_pc", req_q[w + 3], 16'h0001);

        // Asynchronous reset while the high operand byte is outstanding.
        n = 0;
        while (req_q[$] != 16'h0003 && n < 100) begin
            tick();
            n++;
        end
        chk("fetch_hi_reached", req_q[$], 16'h0003);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_ctl", {bus.mem_req_o, bus.valid_o, bus.len_o, bus.opcode_o}, 32'h0);
        chk("async_rst_pc_data", {bus.pc_o, bus.data_o}, 32'h0);
        chk("async_rst_addr", bus.mem_addr_o, 32'h0);

        lat = 1;
        mem[16'h8000] = 8'hC0; mem[16'h8001] = 8'h11; mem[16'h8002] = 8'h80;
        h0 = hs_q.size();
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        take("cpy");
        take("sty");
        chk_bundle("cpy_imm", h0, 8'hC0, 16'h0011, 16'h8000, 2'd2);
        chk_bundle("op80", h0 + 1, 8'h80, 16'h0000, 16'h8002, 2'd1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
